// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART RX: SYNC, LEN, LEN payload bytes, XOR checksum -> indexed payload strobes
// plus one Done/Err pulse per packet. Define UART_RX_PKT_TIMEOUT_EN to add the inter-byte timeout abort.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 1740
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Rx_DV,
    input  logic [7:0]                 i_Rx_Byte,
    output logic                       o_Data_DV,
    output logic [7:0]                 o_Data_Byte,
    output logic [$clog2(MAX_LEN)-1:0] o_Data_Index,
    output logic [7:0]                 o_Pkt_Len,
    output logic                       o_Pkt_Done,
    output logic                       o_Pkt_Err,
    output logic [1:0]                 o_Err_Code,
    output logic                       o_Busy
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      xor_q, xor_d;
    logic            data_dv_q, data_dv_d;
    logic [7:0]      data_byte_q, data_byte_d;
    logic [IW-1:0]   data_index_q, data_index_d;
    logic [7:0]      pkt_len_q, pkt_len_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            busy_q, busy_d;
`ifdef UART_RX_PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS);
    logic [TW-1:0]   tmo_q, tmo_d;
`endif

    // State and output registers; reset drops any packet in flight without an Err pulse.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            xor_q        <= 8'h00;
            data_dv_q    <= 1'b0;
            data_byte_q  <= 8'h00;
            data_index_q <= '0;
            pkt_len_q    <= 8'h00;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            busy_q       <= 1'b0;
`ifdef UART_RX_PKT_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            xor_q        <= xor_d;
            data_dv_q    <= data_dv_d;
            data_byte_q  <= data_byte_d;
            data_index_q <= data_index_d;
            pkt_len_q    <= pkt_len_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PKT_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    // Next-state and next-output logic; a SYNC value past IDLE is treated as ordinary data.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        xor_d        = xor_q;
        data_dv_d    = 1'b0;
        data_byte_d  = data_byte_q;
        data_index_d = data_index_q;
        pkt_len_d    = pkt_len_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
`ifdef UART_RX_PKT_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if ((i_Rx_Byte == 8'h00) || (i_Rx_Byte > 8'(MAX_LEN))) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                        state_d    = S_IDLE;
                    end else begin
                        pkt_len_d = i_Rx_Byte;
                        xor_d     = i_Rx_Byte;
                        count_d   = '0;
                        state_d   = S_PAYLOAD;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    data_dv_d    = 1'b1;
                    data_byte_d  = i_Rx_Byte;
                    data_index_d = count_q[IW-1:0];
                    xor_d        = xor_q ^ i_Rx_Byte;
                    count_d      = count_q + CW'(1);
                    if ((8'(count_q) + 8'd1) == pkt_len_q) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_CSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == xor_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CSUM;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef UART_RX_PKT_TIMEOUT_EN
        // A byte arriving in the terminal cycle is processed above and suppresses the timeout.
        if ((state_q == S_IDLE) || i_Rx_DV) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
            tmo_d      = '0;
            err_d      = 1'b1;
            err_code_d = 2'b11;
            state_d    = S_IDLE;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
`endif
        busy_d = (state_d != S_IDLE);
    end

    assign o_Data_DV    = data_dv_q;
    assign o_Data_Byte  = data_byte_q;
    assign o_Data_Index = data_index_q;
    assign o_Pkt_Len    = pkt_len_q;
    assign o_Pkt_Done   = done_q;
    assign o_Pkt_Err    = err_q;
    assign o_Err_Code   = err_code_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Bench for uart_rx_pkt_ctrl: directed vector table, reset/timeout sequences and random packet streams
// checked byte-by-byte against a packet-parsing reference model.
module tb_uart_rx_pkt_ctrl;
    localparam logic [7:0] SYNC         = 8'hA5;
    localparam int         MAX_LEN      = 16;
    localparam int         TIMEOUT_CLKS = 1740;
    localparam int         IW           = $clog2(MAX_LEN);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          data_dv;
    logic [7:0]    data_byte;
    logic [IW-1:0] data_index;
    logic [7:0]    pkt_len;
    logic          pkt_done;
    logic          pkt_err;
    logic [1:0]    err_code;
    logic          busy;

    uart_rx_pkt_ctrl #(.SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
        .o_Data_DV(data_dv), .o_Data_Byte(data_byte), .o_Data_Index(data_index),
        .o_Pkt_Len(pkt_len), .o_Pkt_Done(pkt_done), .o_Pkt_Err(pkt_err),
        .o_Err_Code(err_code), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          dv;
        logic [7:0]    db;
        logic [IW-1:0] idx;
        logic [7:0]    len;
        logic          done;
        logic          err;
        logic [1:0]    code;
        logic          busy;
    } obs_t;

    typedef struct {
        int         n;
        logic [7:0] b [12];
        int         ndata;
        int         ndone;
        int         nerr;
        logic [1:0] code;
        logic [7:0] len;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cnt_data, cnt_done, cnt_err;
    logic [1:0] m_code = 2'b00;
    logic [7:0] m_len  = 8'h00;
    logic [7:0] stream [$];
    obs_t       exp_q [$];
    vec_t       vt [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.dv   = data_dv;
        o.db   = data_dv ? data_byte : 8'h00;
        o.idx  = data_dv ? data_index : '0;
        o.len  = pkt_len;
        o.done = pkt_done;
        o.err  = pkt_err;
        o.code = err_code;
        o.busy = busy;
        return o;
    endfunction

    // Reference: walk the byte stream as packets and record the expected outputs after each byte.
    task automatic predict();
        int i, n, l;
        logic [7:0] x;
        obs_t o, p;
        i = 0;
        n = stream.size();
        exp_q.delete();
        while (i < n) begin
            o = '0;
            o.len  = m_len;
            o.code = m_code;
            if (stream[i] != SYNC) begin
                exp_q.push_back(o);
                i++;
            end else begin
                o.busy = 1'b1;
                exp_q.push_back(o);
                i++;
                if (i < n) begin
                    l = int'(stream[i]);
                    if (l == 0 || l > MAX_LEN) begin
                        m_code = 2'b10;
                        o.code = m_code;
                        o.err  = 1'b1;
                        o.busy = 1'b0;
                        exp_q.push_back(o);
                        i++;
                    end else begin
                        m_len = stream[i];
                        o.len = m_len;
                        exp_q.push_back(o);
                        i++;
                        x = m_len;
                        for (int k = 0; k < l && i < n; k++) begin
                            p     = o;
                            p.dv  = 1'b1;
                            p.db  = stream[i];
                            p.idx = IW'(k);
                            x     = x ^ stream[i];
                            exp_q.push_back(p);
                            i++;
                        end
                        if (i < n) begin
                            o.busy = 1'b0;
                            if (stream[i] == x) begin
                                o.done = 1'b1;
                            end else begin
                                m_code = 2'b01;
                                o.code = m_code;
                                o.err  = 1'b1;
                            end
                            exp_q.push_back(o);
                            i++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic run_stream(input int max_gap);
        obs_t o, e;
        int g;
        predict();
        cnt_data = 0;
        cnt_done = 0;
        cnt_err  = 0;
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i]);
            o = sample();
            e = exp_q.pop_front();
            check($sformatf("byte%0d(%h)", i, stream[i]), 64'(o), 64'(e));
            cnt_data += int'(data_dv);
            cnt_done += int'(pkt_done);
            cnt_err  += int'(pkt_err);
            g = $urandom_range(max_gap, 0);
            repeat (g) begin
                @(posedge clk);
                #1;
                check("gap_pulses", 64'({data_dv, pkt_done, pkt_err}), 64'(0));
            end
        end
    endtask

    initial begin
        int t, l, k;
        logic [7:0] x, bb;

        vt[0] = '{6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  3, 1, 0, 2'b00, 8'h03};
        vt[1] = '{6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  3, 0, 1, 2'b01, 8'h03};
        vt[2] = '{8, '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00},
                  1, 1, 2, 2'b10, 8'h01};
        vt[3] = '{8, '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00},
                  2, 1, 0, 2'b10, 8'h02};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({data_dv, data_byte, data_index, pkt_len, pkt_done, pkt_err, err_code, busy}),
              64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 4; r++) begin
            stream.delete();
            for (int j = 0; j < vt[r].n; j++) stream.push_back(vt[r].b[j]);
            run_stream(2);
            check($sformatf("row%0d_ndata", r), 64'(cnt_data), 64'(vt[r].ndata));
            check($sformatf("row%0d_ndone", r), 64'(cnt_done), 64'(vt[r].ndone));
            check($sformatf("row%0d_nerr", r), 64'(cnt_err), 64'(vt[r].nerr));
            check($sformatf("row%0d_code", r), 64'(err_code), 64'(vt[r].code));
            check($sformatf("row%0d_len", r), 64'(pkt_len), 64'(vt[r].len));
            check($sformatf("row%0d_busy", r), 64'(busy), 64'(0));
        end

`ifdef UART_RX_PKT_TIMEOUT_EN
        stream = '{8'hA5, 8'h02, 8'h11};
        run_stream(0);
        k = 0;
        while (!pkt_err && k < 2 * TIMEOUT_CLKS) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("timeout_latency", 64'(k), 64'(TIMEOUT_CLKS));
        check("timeout_code", 64'(err_code), 64'(2'b11));
        check("timeout_no_done", 64'(pkt_done), 64'(0));
        m_code = 2'b11;
        @(posedge clk);
        #1;
        check("timeout_busy", 64'(busy), 64'(0));
        stream = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        run_stream(1);
        check("after_timeout_done", 64'(cnt_done), 64'(1));
`endif

        // Reset one cycle after the first payload byte; a DV during reset must be ignored.
        stream = '{8'hA5, 8'h03, 8'h11};
        run_stream(0);
        @(negedge clk);
        rst     = 1'b1;
        rx_dv   = 1'b1;
        rx_byte = SYNC;
        @(posedge clk);
        #1;
        check("midpkt_reset_outputs",
              64'({data_dv, data_byte, data_index, pkt_len, pkt_done, pkt_err, err_code, busy}), 64'(0));
        @(negedge clk);
        rst   = 1'b0;
        rx_dv = 1'b0;
        m_code = 2'b00;
        m_len  = 8'h00;
        @(posedge clk);
        #1;
        check("post_reset_busy", 64'(busy), 64'(0));
        stream.delete();
        for (int j = 0; j < vt[0].n; j++) stream.push_back(vt[0].b[j]);
        run_stream(1);
        check("post_reset_ndata", 64'(cnt_data), 64'(3));
        check("post_reset_ndone", 64'(cnt_done), 64'(1));
        check("post_reset_nerr", 64'(cnt_err), 64'(0));

        for (int p = 0; p < 40; p++) begin
            stream.delete();
            repeat ($urandom_range(2, 0)) begin
                bb = 8'($urandom_range(255, 0));
                if (bb == SYNC) bb = 8'h5A;
                stream.push_back(bb);
            end
            stream.push_back(SYNC);
            t = $urandom_range(3, 0);
            if (t == 3) begin
                l = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, MAX_LEN + 1);
                stream.push_back(8'(l));
            end else begin
                l = $urandom_range(MAX_LEN, 1);
                stream.push_back(8'(l));
                x = 8'(l);
                for (int j = 0; j < l; j++) begin
                    bb = ($urandom_range(7, 0) == 0) ? SYNC : 8'($urandom_range(255, 0));
                    stream.push_back(bb);
                    x = x ^ bb;
                end
                if (t == 2) x = x ^ 8'(1 << $urandom_range(7, 0));
                stream.push_back(x);
            end
            run_stream(3);
            check($sformatf("rand%0d_one_outcome", p), 64'(cnt_done + cnt_err), 64'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
